// File: rtl/double_buffer_pkg.sv
// Shared types and constants for the double_buffer read-side controller.
package double_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned QUEUE_DEPTH  = 2;
    localparam int unsigned QCOUNT_WIDTH = $clog2(QUEUE_DEPTH + 1);

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO that absorbs the SRAM read latency ahead of the stream.
module skid_fifo2
    import double_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [QCOUNT_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0]   head
);

    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;

    // Storage is cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + QCOUNT_WIDTH'(push) - QCOUNT_WIDTH'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/double_buffer_reader.sv
// Drains a contiguous address range of the double_buffer read bank into a valid/ready stream.
module double_buffer_reader
    import double_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned BANK_ADDR_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [BANK_ADDR_WIDTH-1:0] start_adr,
    input  logic [BANK_ADDR_WIDTH:0]   len,
    output logic                       busy,
    output logic                       done,
    output logic                       ren,
    output logic [BANK_ADDR_WIDTH-1:0] radr,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int unsigned LEN_WIDTH = BANK_ADDR_WIDTH + 1;
    localparam int unsigned OCC_WIDTH = QCOUNT_WIDTH + 1;

    state_t                     state;
    state_t                     next_state;
    logic [BANK_ADDR_WIDTH-1:0] adr_cnt;
    logic [LEN_WIDTH-1:0]       issue_cnt;
    logic [LEN_WIDTH-1:0]       accept_cnt;
    logic                       inflight;
    logic [QCOUNT_WIDTH-1:0]    q_count;
    logic [OCC_WIDTH-1:0]       occupancy;
    logic                       credit;
    logic                       pop;

    skid_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_data(rdata),
        .pop      (pop),
        .count    (q_count),
        .head     (out_data)
    );

    assign out_valid = (q_count != '0);
    assign pop       = out_valid && out_ready;
    assign radr      = adr_cnt;

    // Queued words plus the read in flight, net of this cycle's pop, must leave a free slot.
    assign occupancy = OCC_WIDTH'(q_count) + OCC_WIDTH'(inflight) - OCC_WIDTH'(pop);
    assign credit    = (occupancy < OCC_WIDTH'(QUEUE_DEPTH));

    always_comb begin
        next_state = state;
        ren        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                ren = (issue_cnt != '0) && credit;
                if ((issue_cnt == '0) || (ren && (issue_cnt == LEN_WIDTH'(1)))) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if ((accept_cnt == '0) || (pop && (accept_cnt == LEN_WIDTH'(1)))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            adr_cnt    <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= next_state;
            busy     <= (next_state != IDLE);
            done     <= (next_state == DONE);
            inflight <= ren;
            if ((state == IDLE) && start) begin
                adr_cnt    <= start_adr;
                issue_cnt  <= len;
                accept_cnt <= len;
            end else begin
                if (ren) begin
                    adr_cnt   <= adr_cnt + BANK_ADDR_WIDTH'(1);
                    issue_cnt <= issue_cnt - LEN_WIDTH'(1);
                end
                if (pop) begin
                    accept_cnt <= accept_cnt - LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_double_buffer_reader.sv
// Scoreboard bench for double_buffer_reader with a behavioural SRAM and random stalls.
module tb_double_buffer_reader;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_adr;
    logic [AW:0]   len;
    logic          busy, done, ren, out_valid, out_ready;
    logic [AW-1:0] radr;
    logic [DW-1:0] rdata, out_data;

    double_buffer_reader #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_adr(start_adr), .len(len),
        .busy(busy), .done(done), .ren(ren), .radr(radr), .rdata(rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram [2**AW];
    always @(posedge clk) if (ren) rdata <= sram[radr];

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] adr_q [$];
    int  outstanding = 0;
    int  ren_total = 0;
    int  rdy_mode = 0;
    bit  prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Consumer ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int phase = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            phase++;
            case (rdy_mode)
                1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
                2:       out_ready = 1'($urandom);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: addresses, data ordering, stall stability, outstanding-word bound.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk(out_valid, "valid_held", 64'(out_valid), 64'd1);
                    chk(out_data == prev_data, "data_stable", out_data, prev_data);
                end
                if (ren) begin
                    ren_total++;
                    outstanding++;
                    if (adr_q.size() == 0) chk(1'b0, "unexpected_ren", 64'(radr), 64'd0);
                    else begin
                        logic [AW-1:0] ea;
                        ea = adr_q.pop_front();
                        chk(radr == ea, "radr", 64'(radr), 64'(ea));
                    end
                end
                if (out_valid && out_ready) begin
                    outstanding--;
                    if (exp_q.size() == 0) chk(1'b0, "unexpected_word", out_data, 64'd0);
                    else begin
                        logic [DW-1:0] ed;
                        ed = exp_q.pop_front();
                        chk(out_data == ed, "out_data", out_data, ed);
                    end
                end
                if (ren) chk(outstanding <= 2, "outstanding_le_2", 64'(outstanding), 64'd2);
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic check_reset_values();
        chk(!busy, "rst_busy", 64'(busy), 64'd0);
        chk(!done, "rst_done", 64'(done), 64'd0);
        chk(!ren, "rst_ren", 64'(ren), 64'd0);
        chk(radr == '0, "rst_radr", 64'(radr), 64'd0);
        chk(!out_valid, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(out_data == '0, "rst_out_data", out_data, 64'd0);
    endtask

    // One command; called and returns just after a rising edge.
    task automatic run(input logic [AW-1:0] sa, input logic [AW:0] n, input int mode,
                       input int restart_at, input int rst_at);
        int k;
        int ren0;
        int want;
        bit got = 0;
        rdy_mode = mode;
        k = 0;
        while (busy && k < 1000) begin @(posedge clk); #1; k++; end
        start = 1'b1; start_adr = sa; len = n;
        for (int i = 0; i < int'(n); i++) begin
            adr_q.push_back(AW'(int'(sa) + i));
            exp_q.push_back(sram[AW'(int'(sa) + i)]);
        end
        ren0 = ren_total;
        @(posedge clk); #1;
        start_adr = AW'($urandom); len = (AW+1)'($urandom_range(1, 20));
        for (k = 1; k <= 1000; k++) begin
            start = (k == restart_at);
            if (k == rst_at) rst_n = 1'b0;
            @(negedge clk);
            if (k == rst_at) begin
                @(posedge clk); #1;
                rst_n = 1'b1; start = 1'b0;
                exp_q.delete(); adr_q.delete(); outstanding = 0;
                @(negedge clk);
                check_reset_values();
                @(posedge clk); #1;
                return;
            end
            if (k == 1) chk(busy, "busy_cycle1", 64'(busy), 64'd1);
            if (k == 1 && n != 0) chk(ren, "ren_cycle1", 64'(ren), 64'd1);
            if (mode == 0 && n != 0 && k == 2) chk(!out_valid, "valid_cycle2", 64'(out_valid), 64'd0);
            if (mode == 0 && n != 0 && k == 3) chk(out_valid, "valid_cycle3", 64'(out_valid), 64'd1);
            if (n == 0 && (out_valid || ren)) chk(1'b0, "len0_activity", 64'({out_valid, ren}), 64'd0);
            if (done) begin got = 1; break; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk(got, "done_seen", 64'(got), 64'd1);
        want = (n == 0) ? 1 : int'(n) + 3;
        if (mode == 0) chk(k == want, "done_cycle", 64'(k), 64'(want));
        chk(ren_total - ren0 == int'(n), "ren_pulses", 64'(ren_total - ren0), 64'(n));
        chk(exp_q.size() == 0, "all_words_delivered", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk(!done, "done_single_pulse", 64'(done), 64'd0);
        chk(!busy, "idle_after_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int a = 0; a < 2**AW; a++) sram[a] = {32'($urandom), 25'($urandom), 7'(a)};
        rst_n = 1'b0; start = 1'b0; start_adr = '0; len = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(7'd0,   8'd8,  0, 0, 0);
        run(7'd126, 8'd4,  0, 0, 0);
        run(7'd127, 8'd3,  0, 0, 0);
        run(7'd40,  8'd16, 1, 0, 0);
        run(7'd5,   8'd0,  0, 0, 0);
        run(7'd20,  8'd10, 0, 0, 5);
        run(7'd90,  8'd2,  0, 0, 0);
        run(7'd60,  8'd12, 0, 2, 0);
        run(7'd10,  8'd128, 2, 0, 0);
        for (int t = 0; t < 25; t++) begin
            run(AW'($urandom), (AW+1)'($urandom_range(0, 40)), int'($urandom_range(0, 2)), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/double_buffer_reader.md
# double_buffer_reader

Read-side controller for a `double_buffer` instance. On a start command it drains a contiguous range of the current read bank into a valid/ready output stream. It hides the SRAM's 1-cycle read latency behind a 2-entry output queue, so the stream runs at one word per cycle when the consumer does not stall. When the last word has been accepted downstream it signals `done`; top-level control uses that pulse to assert `switch_banks`.

## Interface
- `DATA_WIDTH`, 64, word width; equals the `double_buffer` data width.
- `BANK_ADDR_WIDTH`, 7, bank address width; equals the `double_buffer` bank address width.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  command pulse; accepted only in IDLE.
- `start_adr`  in  BANK_ADDR_WIDTH  first bank address to read.
- `len`  in  BANK_ADDR_WIDTH+1  number of words to read, 0..2^BANK_ADDR_WIDTH.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last word handshake.
- `ren`  out  1  to `double_buffer.ren`.
- `radr`  out  BANK_ADDR_WIDTH  to `double_buffer.radr`.
- `rdata`  in  DATA_WIDTH  from `double_buffer.rdata`; valid the cycle after `ren`.
- `out_data`  out  DATA_WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.

## Operation
- States:
  - IDLE: on `start`, latch `start_adr` into the address counter and `len` into the issue and accept counters.
    - `len`≠0 → READ.
    - `len`=0 → DONE, and no reads are issued.
  - READ: issue reads.
    - `ren` = (issue counter ≠ 0) && credit.
    - Each `ren` increments the address counter and decrements the issue counter.
    - Issue counter reaches 0 → DRAIN.
  - DRAIN: wait until the accept counter reaches 0 → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Credit: q_count + inflight − (out_valid && out_ready) < 2. This is combinational on `out_ready`.
- `inflight` is a register set to `ren` every cycle. While `inflight`=1, `rdata` is pushed into the queue at the clock edge.
- `out_valid` = queue not empty; `out_data` = queue head.
- Each handshake pops the queue and decrements the accept counter.
- The address counter wraps modulo 2^BANK_ADDR_WIDTH; `start_adr`=127 with `len`=3 reads 127, 0, 1.
- `radr` = address counter register; its value is only meaningful while `ren`=1.
- `start` outside IDLE is ignored; there is no queueing of commands.
- Queue overflow is impossible by construction. The bench asserts this condition never occurs.

## Timing
- Reset state:
  - IDLE.
  - `busy`=0, `done`=0, `ren`=0, `radr`=0, `out_valid`=0, `out_data`=0.
  - Queue empty, `inflight`=0.
- Reset mid-operation takes effect on the next edge:
  - Any read in flight is discarded.
  - Queued words are dropped.
  - No `done` is produced.
- Command at cycle 0 (`start` sampled): `busy` and first `ren` at cycle 1; first `out_valid` at cycle 3.
- With `out_ready` held high, one word is delivered per cycle. For N words:
  - last handshake at cycle N+2;
  - `done` at cycle N+3;
  - IDLE at cycle N+4, when `start` is accepted again.
- With `len`=0: `done` at cycle 1, IDLE at cycle 2.
- `out_valid` never drops without a handshake, and `out_data` is stable while stalled.

## Structure
- Package `double_buffer_pkg` holds the state enum (IDLE, READ, DRAIN, DONE) and the queue depth constant (2).
- Sub-module `skid_fifo2`: 2-entry synchronous FIFO with push/pop, count, head, and the same reset style.
- All state is registered except `ren`, credit, and the pop signal.

## Test plan
- Directed scenarios:
  - `start_adr`=0, `len`=8, `out_ready`=1, SRAM preloaded with data equal to address → data 0..7 on cycles 3..10; `done` at cycle 11; exactly 8 `ren` pulses.
  - `start_adr`=126, `len`=4 → `radr` sequence 126, 127, 0, 1; data order matches.
  - `len`=16 with `out_ready` toggling 1,0,0,1 → no loss or duplication; `out_data` stable during stalls; `ren` never asserted with credit=0.
  - `len`=0 → `done` at cycle 1; no `ren`; `out_valid` stays 0.
  - `rst_n`=0 for 1 cycle at cycle 5 of a `len`=10 read → all outputs at reset values next cycle; a subsequent `len`=2 read returns correct data.
  - `start` re-asserted during READ → ignored; exactly the original `len` words delivered; single `done`.
- Coverage across all scenarios: queue overflow assertion never fires.
